// File: rtl/input_cond_pkg.sv
// Shared types and constants for the push-button input conditioner.
// Optional feature: define HOLD_REPEAT_EN to enable hold-to-repeat pulses.
package input_cond_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } cond_state_t;

    function automatic logic is_confirm(input cond_state_t st);
        return (st == CONFIRM_PRESS) || (st == CONFIRM_RELEASE);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, debounce FSM/counter, press pulse.
// Hold-to-repeat pulses are built only when HOLD_REPEAT_EN is defined.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned RepeatDelay    = 25000000,
    parameter int unsigned RepeatPeriod   = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o,
    output logic busy_o
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntSat  = '1;

    if (DebounceCycles < 1 || RepeatDelay < 1 || RepeatPeriod < 1) begin : g_bad_cfg
        $error("debounce_channel: DebounceCycles/RepeatDelay/RepeatPeriod must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    cond_state_t            state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned RptMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    logic [RptW-1:0] rpt_q, rpt_d, rpt_last;
    // Low while waiting out the initial delay, high once into periodic repeats.
    logic            rpt_period_q, rpt_period_d;

    assign rpt_last = rpt_period_q ? RptW'(RepeatPeriod - 1) : RptW'(RepeatDelay - 1);
`endif

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef HOLD_REPEAT_EN
        rpt_d        = rpt_q;
        rpt_period_d = rpt_period_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = CONFIRM_PRESS;
                    cnt_d   = '0;
                end
            end
            CONFIRM_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CntLast) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef HOLD_REPEAT_EN
                    rpt_d        = '0;
                    rpt_period_d = 1'b0;
`endif
                end else if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = CONFIRM_RELEASE;
                    cnt_d   = '0;
                end
`ifdef HOLD_REPEAT_EN
                else if (rpt_q == rpt_last) begin
                    pulse_d      = 1'b1;
                    rpt_d        = '0;
                    rpt_period_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + RptW'(1);
                end
`endif
            end
            CONFIRM_RELEASE: begin
                // Bouncing back resumes PRESSED; the repeat counter stays frozen meanwhile.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CntLast) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            busy_q  <= is_confirm(state_d);
        end
    end

`ifdef HOLD_REPEAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_q        <= '0;
            rpt_period_q <= 1'b0;
        end else begin
            rpt_q        <= rpt_d;
            rpt_period_q <= rpt_period_d;
        end
    end
`endif

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/input_conditioner.sv
// N_BTN independent debounced push-button channels with press pulses.
// Define HOLD_REPEAT_EN to add auto-repeat pulses while a button is held.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             busy
);

    logic [N_BTN-1:0] chan_busy;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DebounceCycles (DEBOUNCE_CYCLES),
            .RepeatDelay    (REPEAT_DELAY),
            .RepeatPeriod   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i   (clk),
            .rst_ni  (reset),
            .raw_i   (btn_raw[i]),
            .level_o (btn_level[i]),
            .pulse_o (btn_pulse[i]),
            .busy_o  (chan_busy[i])
        );
    end

    // Each per-channel flag is already a flop, so busy has no path from btn_raw.
    assign busy = |chan_busy;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random bouncing
// stimulus compared against a run-length reference model.
module tb_input_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;
    logic         busy;

    input_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: s is raw delayed by two edges; a change is accepted after D+1
    // consecutive samples of s that disagree with the current level.
    bit m_s1[N], m_s2[N], m_lvl[N], m_pls[N];
    int m_run[N], m_hold[N];

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pls[c] = 0;
            m_run[c] = 0; m_hold[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        for (int c = 0; c < N; c++) begin
            bit s;
            s = m_s2[c];
            m_pls[c] = 0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    if (s) begin
                        m_pls[c] = 1;
                        m_hold[c] = 0;
                    end
                end
            end else begin
`ifdef HOLD_REPEAT_EN
                if (m_lvl[c] && m_run[c] == 0) begin
                    m_hold[c]++;
                    if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0))
                        m_pls[c] = 1;
                end
`endif
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] el, ep;
        logic eb;
        eb = 1'b0;
        for (int c = 0; c < N; c++) begin
            el[c] = m_lvl[c];
            ep[c] = m_pls[c];
            eb |= (m_run[c] > 0);
        end
        check("level", 32'(btn_level), 32'(el));
        check("pulse", 32'(btn_pulse), 32'(ep));
        check("busy", 32'(busy), 32'(eb));
    endtask

    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (reset) model_edge(raw);
        else model_clear();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_pulse", 32'(btn_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic settle();
        for (int k = 0; k < 14; k++) step('0);
    endtask

    initial begin
        logic [N-1:0] raw_r;
        int rem[N];
        bit saw_busy;
        bit rep;

        model_clear();
        #2;
        apply_reset();
        repeat (3) step('0);
        #3;
        reset = 1'b1;
        settle();

        // Clean press on ch0.
        for (int k = 0; k < 10; k++) begin
            step(4'b0001);
            check("press_pulse0", 32'(btn_pulse[0]), 32'(k == 6));
            check("press_level0", 32'(btn_level[0]), 32'(k >= 6));
            check("press_others", 32'(btn_level[3:1] | btn_pulse[3:1]), 32'd0);
        end
        // Release bounce back to 1 while confirming release.
        for (int k = 0; k < 9; k++) begin
            step((k < 3 || k >= 5) ? 4'b0000 : 4'b0001);
            if (k >= 5) btn_raw = 4'b0001;
            check("rel_bounce_level", 32'(btn_level[0]), 32'd1);
        end
        for (int k = 0; k < 4; k++) step(4'b0001);
        for (int k = 0; k < 10; k++) begin
            step(4'b0000);
            check("rel_level", 32'(btn_level[0]), 32'(k < 6));
            check("rel_nopulse", 32'(btn_pulse[0]), 32'd0);
        end
        settle();

        // Bounce on ch1: never accepted.
        saw_busy = 0;
        for (int k = 0; k < 16; k++) begin
            step((k < 8 && k % 2 == 0) ? 4'b0010 : 4'b0000);
            if (busy) saw_busy = 1;
            check("bounce_level1", 32'(btn_level[1]), 32'd0);
            check("bounce_pulse1", 32'(btn_pulse[1]), 32'd0);
        end
        check("bounce_busy_seen", 32'(saw_busy), 32'd1);
        settle();

        // Simultaneous press on all channels.
        for (int k = 0; k < 10; k++) begin
            step(4'hF);
            check("all_pulse", 32'(btn_pulse), (k == 6) ? 32'hF : 32'h0);
        end
        settle();

        // Reset mid-press, button held through release.
        for (int k = 0; k < 18; k++) begin
            if (k == 10) reset = 1'b1;
            step(4'b0001);
            if (k == 4) apply_reset();
            if (k >= 5 && k < 10) check("rst_hold_zero", 32'({btn_level, btn_pulse, busy}), 32'd0);
            check("rst_rel_pulse", 32'(btn_pulse[0]), 32'(k == 16));
        end
        settle();

        // Long hold: one pulse, or auto-repeat when enabled.
        for (int k = 0; k < 34; k++) begin
            step(4'b0001);
`ifdef HOLD_REPEAT_EN
            rep = (k >= 16 && (k - 16) % RP == 0);
`else
            rep = 0;
`endif
            check("hold_pulse", 32'(btn_pulse[0]), 32'(k == 6 || rep));
        end
        settle();

        // Random bouncing and holds on all channels, with occasional resets.
        raw_r = '0;
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    raw_r[c] = ~raw_r[c];
                    rem[c] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 40))
                                                          : int'($urandom_range(1, 7));
                end
                rem[c]--;
            end
            if (cyc % 1000 == 999) begin
                apply_reset();
                repeat (2) step(raw_r);
                reset = 1'b1;
            end
            step(raw_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

- Conditions raw asynchronous push-button inputs before they reach the flip-flop register and counter stages.
- Per channel, it synchronizes, debounces and edge-detects the input, producing a clean level plus a single-cycle press pulse.
- Downstream registers clock in `btn_pulse` directly as their data/enable, so no metastable or bouncing signal reaches them.

## Interface
Parameters:
- `N_BTN`, 4, number of independent button channels (≥1)
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required to accept a change (≥1)
- `REPEAT_DELAY`, 25000000, hold cycles before the first auto-repeat pulse (used only with `HOLD_REPEAT_EN`; ≥1)
- `REPEAT_PERIOD`, 5000000, cycles between subsequent auto-repeat pulses (used only with `HOLD_REPEAT_EN`; ≥1)

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge
- `reset`  in  1  asynchronous, active-low reset; all state is cleared while it is 0
- `btn_raw`  in  N_BTN  raw pad inputs, asynchronous, active-high
- `btn_level`  out  N_BTN  debounced level, registered
- `btn_pulse`  out  N_BTN  one-cycle press pulse, registered
- `busy`  out  1  OR over channels in a CONFIRM_* state, registered

## Operation
- **Synchronizer:** each `btn_raw[i]` passes through a 2-flop synchronizer; the FSM uses only the second-stage output `s`.
- **Counter:** each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
- **FSM states:** IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
  - IDLE: if s=1, go to CONFIRM_PRESS with cnt←0.
  - CONFIRM_PRESS: if s=0, go to IDLE (no pulse, bounce rejected). Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set `btn_level`=1 and `btn_pulse`=1 for one cycle. Otherwise cnt++.
  - PRESSED: if s=0, go to CONFIRM_RELEASE with cnt←0.
  - CONFIRM_RELEASE: if s=1, return to PRESSED (no pulse). Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE and set `btn_level`=0. Otherwise cnt++.
- **Output rules:**
  - Exactly one `btn_pulse` per accepted press.
  - No pulse on release.
  - `btn_level` changes only on accepted transitions.
- **Channel independence:** channels share no state. Simultaneous presses on several channels give simultaneous pulses.
- **Reset:** while `reset`=0, all of the following are 0: synchronizer flops, counters, `btn_level`, `btn_pulse`, `busy`, and FSM state (IDLE).
  - Reset mid-CONFIRM discards the pending change.
  - A button held through reset release is accepted as a new press after the full latency below.

## Timing
- Edge 0 is the first rising edge sampling `btn_raw[i]`=1, and raw stays stable.
  - `btn_pulse[i]` and `btn_level[i]` are high from edge DEBOUNCE_CYCLES+2 to the next edge (pulse).
  - `btn_level` stays high after that.
- Release latency is likewise DEBOUNCE_CYCLES+2 edges from the first edge sampling 0.
- Any glitch shorter than DEBOUNCE_CYCLES cycles, as seen at `s`, produces no output change.
- `busy` is high in the cycle after any channel enters a CONFIRM_* state. It falls in the cycle after the last such channel leaves it.
- No combinational path from `btn_raw` to any output.

## Configuration
- Macro: `HOLD_REPEAT_EN`.
- **Defined:** PRESSED also runs a repeat counter, cleared on entry to PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, emit one `btn_pulse`.
  - Then emit one pulse every REPEAT_PERIOD cycles while PRESSED.
  - Entering CONFIRM_RELEASE freezes the repeat counter. Returning to PRESSED from CONFIRM_RELEASE resumes it without clearing.
- **Undefined:**
  - The repeat logic and its counter are not synthesized.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
  - Exactly one pulse is emitted per press regardless of hold time.

## Structure
- Package `input_cond_pkg`:
  - `cond_state_t` enum (IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE)
  - `SYNC_STAGES`=2 constant
- Sub-module `debounce_channel`: synchronizer, FSM, counter and optional repeat logic for one bit.
- `input_conditioner` instantiates N_BTN `debounce_channel`s in a generate loop and ORs their busy flags.

## Test plan
Directed scenarios, all with DEBOUNCE_CYCLES=4:
- Clean press on ch0, raw=1 held from edge 0 → `btn_pulse[0]`=1 only after edge 6; `btn_level[0]`=1 from edge 6; no other channel toggles.
- Bounce: raw ch1 toggles 1,0,1,0 each cycle for 8 cycles, then stays 0 → `btn_pulse[1]` never asserts; `busy` pulses; `btn_level[1]` stays 0.
- Release with 2-cycle bounce back to 1 mid-CONFIRM_RELEASE → level stays 1 and no pulse; a clean release 0 for ≥4 cycles clears level 6 edges after it starts.
- Simultaneous press on all 4 channels at edge 0 → `btn_pulse`=4'hF for exactly one cycle after edge 6.
- Reset asserted (0) at edge 4 of a press, released at edge 10 with raw held 1 → all outputs 0 during reset; pulse arrives 6 edges after the first edge following reset release.
- With `HOLD_REPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=3, hold 30 cycles → pulses at edges 6, 16, 19, 22, 25, 28, 31 relative to edge 0. Without the macro, only the pulse at edge 6.
